// File: rtl/audio_mem_pkg.sv
// Shared types and sizing helpers for the audio playback memory.
// Width helpers keep the top, FIFO and interface in agreement.
package audio_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  function automatic int len_w(int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int ch_w(int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Drop any partial trailing frame; channels is a power of two.
  function automatic int unsigned frame_align(
    int unsigned len,
    int unsigned channels
  );
    return len & ~(channels - 1);
  endfunction

endpackage

// File: rtl/audio_playback_memory_if.sv
// Bus bundle: Avalon-MM port A, playback control, Avalon-ST source.
// AUDIO_MEM_POS_OUT_EN adds play_pos and loop_count.
interface audio_playback_memory_if #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 17,
  parameter int CHANNELS = 2
);
  import audio_mem_pkg::*;

  localparam int CH_W  = ch_w(CHANNELS);
  localparam int LEN_W = len_w(ADDR_W);

  logic [ADDR_W-1:0]   avs_address;
  logic [DATA_W/8-1:0] avs_byteenable;
  logic                avs_chipselect;
  logic                avs_write;
  logic [DATA_W-1:0]   avs_writedata;
  logic                avs_read;
  logic [DATA_W-1:0]   avs_readdata;

  logic                ctl_start;
  logic                ctl_stop;
  logic                ctl_loop;
  logic [ADDR_W-1:0]   ctl_base;
  logic [LEN_W-1:0]    ctl_length;

  logic [DATA_W-1:0]   src_data;
  logic [CH_W-1:0]     src_channel;
  logic                src_sop;
  logic                src_eop;
  logic                src_valid;
  logic                src_ready;

  logic                busy;
  logic                done;

`ifdef AUDIO_MEM_POS_OUT_EN
  logic [LEN_W-1:0]    play_pos;
  logic [15:0]         loop_count;

  modport slave (
    input  avs_address, avs_byteenable,
    input  avs_chipselect, avs_write,
    input  avs_writedata, avs_read,
    output avs_readdata,
    input  ctl_start, ctl_stop, ctl_loop,
    input  ctl_base, ctl_length,
    output src_data, src_channel,
    output src_sop, src_eop, src_valid,
    input  src_ready,
    output busy, done,
    output play_pos, loop_count
  );

  modport master (
    output avs_address, avs_byteenable,
    output avs_chipselect, avs_write,
    output avs_writedata, avs_read,
    input  avs_readdata,
    output ctl_start, ctl_stop, ctl_loop,
    output ctl_base, ctl_length,
    input  src_data, src_channel,
    input  src_sop, src_eop, src_valid,
    output src_ready,
    input  busy, done,
    input  play_pos, loop_count
  );
`else
  modport slave (
    input  avs_address, avs_byteenable,
    input  avs_chipselect, avs_write,
    input  avs_writedata, avs_read,
    output avs_readdata,
    input  ctl_start, ctl_stop, ctl_loop,
    input  ctl_base, ctl_length,
    output src_data, src_channel,
    output src_sop, src_eop, src_valid,
    input  src_ready,
    output busy, done
  );

  modport master (
    output avs_address, avs_byteenable,
    output avs_chipselect, avs_write,
    output avs_writedata, avs_read,
    input  avs_readdata,
    output ctl_start, ctl_stop, ctl_loop,
    output ctl_base, ctl_length,
    input  src_data, src_channel,
    input  src_sop, src_eop, src_valid,
    output src_ready,
    input  busy, done
  );
`endif

endinterface

// File: rtl/audio_mem_out_fifo.sv
// Two-entry output FIFO for {sample, channel} with flush.
// Head entry stays put until popped, so stalled outputs hold.
module audio_mem_out_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         flush,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   count
);

  logic [W-1:0] slot_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         pop;

  assign valid = (cnt_q != 2'd0);
  assign pop   = valid & ready;
  assign data  = slot_q[rd_q];
  assign count = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= 2'd0;
    end else if (flush) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        slot_q[wr_q] <= push_data;
        wr_q         <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/audio_playback_memory.sv
// Dual-port sample RAM: Avalon-MM load port, looping stream player.
// AUDIO_MEM_POS_OUT_EN adds play_pos/loop_count position outputs.
module audio_playback_memory #(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 17,
  parameter int    CHANNELS  = 2,
  parameter string INIT_FILE = "audio_playback_memory.hex"
) (
  input logic clk,
  input logic reset,
  audio_playback_memory_if.slave bus
);
  import audio_mem_pkg::*;

  localparam int CH_W  = ch_w(CHANNELS);
  localparam int LEN_W = len_w(ADDR_W);
  localparam int NB    = DATA_W / 8;
  localparam logic [CH_W-1:0] CH_LAST =
    CH_W'(CHANNELS - 1);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    off_q;
  logic                loop_q;
  logic [CH_W-1:0]     ch_q;
  logic [CH_W-1:0]     rd_ch_q;
  logic                inflight_q;
  logic                done_q;

  logic                issue;
  logic                flush;
  logic                start_ok;
  logic                done_d;
  logic                off_last;
  logic                space;
  logic                pop;
  logic [2:0]          occ;
  logic [LEN_W-1:0]    start_len;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data;

  logic [1:0]          fifo_count;
  logic                fifo_valid;
  logic [DATA_W+CH_W-1:0] fifo_out;
  logic [DATA_W-1:0]   fifo_data;
  logic [CH_W-1:0]     fifo_ch;

  assign start_len = LEN_W'(frame_align(
    int'(bus.ctl_length), CHANNELS));
  assign rd_addr  = base_q + off_q[ADDR_W-1:0];
  assign off_last = (off_q + LEN_W'(1) == len_q);
  assign pop      = fifo_valid & bus.src_ready;

  // Count the word leaving this cycle so the stream never bubbles.
  assign occ   = 3'(fifo_count) + 3'(inflight_q)
               - 3'(pop);
  assign space = (occ < 3'd2);

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    flush    = 1'b0;
    start_ok = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ctl_start && !bus.ctl_stop) begin
          start_ok = 1'b1;
          if (start_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.ctl_stop) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (space) begin
          issue = 1'b1;
          if (off_last && !loop_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.ctl_stop) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (fifo_count == 2'd0 &&
                     !inflight_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      off_q      <= '0;
      loop_q     <= 1'b0;
      ch_q       <= '0;
      rd_ch_q    <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      inflight_q <= issue;
      if (start_ok) begin
        base_q <= bus.ctl_base;
        len_q  <= start_len;
        loop_q <= bus.ctl_loop;
        off_q  <= '0;
        ch_q   <= '0;
      end else if (issue) begin
        off_q   <= off_last ? '0 : off_q + LEN_W'(1);
        ch_q    <= (ch_q == CH_LAST) ? '0
                 : ch_q + CH_W'(1);
        rd_ch_q <= ch_q;
      end
    end
  end

  // Port B read sees the pre-write contents on an address clash.
  always_ff @(posedge clk) begin
    if (bus.avs_chipselect && bus.avs_write) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.avs_byteenable[i]) begin
          mem[bus.avs_address][i*8 +: 8] <=
            bus.avs_writedata[i*8 +: 8];
        end
      end
    end
    if (issue) begin
      rd_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.avs_readdata <= '0;
    end else if (bus.avs_chipselect &&
                 bus.avs_read && !bus.avs_write) begin
      bus.avs_readdata <= mem[bus.avs_address];
    end
  end

  audio_mem_out_fifo #(
    .W(DATA_W + CH_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight_q),
    .push_data({rd_data, rd_ch_q}),
    .flush    (flush),
    .ready    (bus.src_ready),
    .valid    (fifo_valid),
    .data     (fifo_out),
    .count    (fifo_count)
  );

  assign {fifo_data, fifo_ch} = fifo_out;
  assign bus.src_data    = fifo_data;
  assign bus.src_channel = fifo_ch;
  assign bus.src_valid   = fifo_valid;
  assign bus.src_sop     = fifo_valid & (fifo_ch == '0);
  assign bus.src_eop     = fifo_valid & (fifo_ch == CH_LAST);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;

`ifdef AUDIO_MEM_POS_OUT_EN
  logic [LEN_W-1:0] pos_q;
  logic [15:0]      loops_q;
  logic             pos_last;

  assign pos_last = (pos_q + LEN_W'(1) == len_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q   <= '0;
      loops_q <= '0;
    end else if (start_ok) begin
      pos_q   <= '0;
      loops_q <= '0;
    end else if (pop) begin
      pos_q <= pos_last ? '0 : pos_q + LEN_W'(1);
      if (pos_last && loop_q && loops_q != 16'hFFFF) begin
        loops_q <= loops_q + 16'd1;
      end
    end
  end

  assign bus.play_pos   = pos_q;
  assign bus.loop_count = loops_q;
`endif

endmodule

// File: tb/tb_audio_playback_memory.sv
// Directed bench for audio_playback_memory (CHANNELS=2, ADDR_W=17).
// Define AUDIO_MEM_POS_OUT_EN to also cover play_pos/loop_count.
`timescale 1ns/1ps
module tb_audio_playback_memory;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 17;
  localparam int CHANNELS = 2;
  localparam int MAXA     = (1 << ADDR_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  int q_data[$];
  int q_ch[$];
  int q_sop[$];
  int q_eop[$];

  audio_playback_memory_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CHANNELS(CHANNELS)
  ) bus ();

  audio_playback_memory #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CHANNELS(CHANNELS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.avs_address    = '0;
    bus.avs_byteenable = '0;
    bus.avs_chipselect = 1'b0;
    bus.avs_write      = 1'b0;
    bus.avs_writedata  = '0;
    bus.avs_read       = 1'b0;
    bus.ctl_start      = 1'b0;
    bus.ctl_stop       = 1'b0;
    bus.ctl_loop       = 1'b0;
    bus.ctl_base       = '0;
    bus.ctl_length     = '0;
    bus.src_ready      = 1'b0;
  endtask

  task automatic mem_write(input int a, input int d, input int be);
    bus.avs_chipselect = 1'b1;
    bus.avs_write      = 1'b1;
    bus.avs_address    = ADDR_W'(a);
    bus.avs_writedata  = DATA_W'(d);
    bus.avs_byteenable = 2'(be);
    tick();
    bus.avs_chipselect = 1'b0;
    bus.avs_write      = 1'b0;
  endtask

  task automatic mem_read(input int a);
    bus.avs_chipselect = 1'b1;
    bus.avs_read       = 1'b1;
    bus.avs_address    = ADDR_W'(a);
    tick();
    bus.avs_chipselect = 1'b0;
    bus.avs_read       = 1'b0;
  endtask

  task automatic start_play(input int base, input int len, input bit lp);
    bus.ctl_base   = ADDR_W'(base);
    bus.ctl_length = (ADDR_W+1)'(len);
    bus.ctl_loop   = lp;
    bus.ctl_start  = 1'b1;
    tick();
    bus.ctl_start  = 1'b0;
  endtask

  // Gathers up to n transfers within budget cycles; counts stall glitches.
  task automatic collect(input int n, input bit rnd, input int budget,
                         output int got, output int bad, output int dn);
    logic [15:0] hd;
    int hc, hs, he;
    bit pend;
    pend = 1'b0;
    hd = '0; hc = 0; hs = 0; he = 0;
    got = 0; bad = 0; dn = 0;
    q_data.delete(); q_ch.delete();
    q_sop.delete(); q_eop.delete();
    for (int c = 0; c < budget && got < n; c++) begin
      if (bus.done) dn++;
      if (pend) begin
        if (!bus.src_valid || bus.src_data !== hd ||
            int'(bus.src_channel) != hc ||
            int'(bus.src_sop) != hs || int'(bus.src_eop) != he)
          bad++;
      end
      bus.src_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.src_valid && bus.src_ready) begin
        q_data.push_back(int'(bus.src_data));
        q_ch.push_back(int'(bus.src_channel));
        q_sop.push_back(int'(bus.src_sop));
        q_eop.push_back(int'(bus.src_eop));
        got++;
        pend = 1'b0;
      end else if (bus.src_valid) begin
        pend = 1'b1;
        hd = bus.src_data;
        hc = int'(bus.src_channel);
        hs = int'(bus.src_sop);
        he = int'(bus.src_eop);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({bus.src_valid, bus.src_sop, bus.src_eop,
         bus.busy, bus.done} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b expected 00000",
        {bus.src_valid, bus.src_sop, bus.src_eop,
         bus.busy, bus.done});
    end
    vectors++;
    if (bus.avs_readdata !== 16'h0 || bus.src_data !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%h expected 0000/0000",
        bus.avs_readdata, bus.src_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_port_a();
    mem_write(5, 'hFFFF, 3);
    mem_write(5, 'hA5C3, 1);
    mem_read(5);
    vectors++;
    if (bus.avs_readdata !== 16'hFFC3) begin
      miscompares++;
      $display("FAIL porta_be_lo: got %h expected ffc3",
        bus.avs_readdata);
    end
    tick();
    vectors++;
    if (bus.avs_readdata !== 16'hFFC3) begin
      miscompares++;
      $display("FAIL porta_hold: got %h expected ffc3",
        bus.avs_readdata);
    end
    bus.avs_chipselect = 1'b1;
    bus.avs_write      = 1'b1;
    bus.avs_read       = 1'b1;
    bus.avs_address    = 17'd6;
    bus.avs_writedata  = 16'h5555;
    bus.avs_byteenable = 2'b11;
    tick();
    idle_inputs();
    vectors++;
    if (bus.avs_readdata !== 16'hFFC3) begin
      miscompares++;
      $display("FAIL porta_wr_rd: got %h expected ffc3",
        bus.avs_readdata);
    end
    mem_read(6);
    vectors++;
    if (bus.avs_readdata !== 16'h5555) begin
      miscompares++;
      $display("FAIL porta_wr_rd_data: got %h expected 5555",
        bus.avs_readdata);
    end
    mem_write(7, 'h0000, 3);
    mem_write(7, 'h12AB, 2);
    mem_read(7);
    vectors++;
    if (bus.avs_readdata !== 16'h1200) begin
      miscompares++;
      $display("FAIL porta_be_hi: got %h expected 1200",
        bus.avs_readdata);
    end
  endtask

  task automatic preload();
    for (int a = 100; a < 106; a++) mem_write(a, 'h1000 + a, 3);
    mem_write(MAXA - 1, 'hBEE0, 3);
    mem_write(MAXA,     'hBEE1, 3);
    mem_write(0,        'hBEE2, 3);
    mem_write(1,        'hBEE3, 3);
  endtask

  task automatic test_one_shot();
    int got, bad, dn, pulses;
    bus.src_ready = 1'b1;
    start_play(100, 6, 1'b0);
    vectors++;
    if (bus.busy !== 1'b1 || bus.src_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL oneshot_lat0: got busy=%b valid=%b expected 1/0",
        bus.busy, bus.src_valid);
    end
    tick();
    vectors++;
    if (bus.src_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL oneshot_lat1: got valid=%b expected 0",
        bus.src_valid);
    end
    tick();
    vectors++;
    if (bus.src_valid !== 1'b1 || bus.src_data !== 16'h1064) begin
      miscompares++;
      $display("FAIL oneshot_first: got valid=%b data=%h expected 1/1064",
        bus.src_valid, bus.src_data);
    end
    collect(6, 1'b0, 20, got, bad, dn);
    vectors++;
    if (got != 6) begin
      miscompares++;
      $display("FAIL oneshot_count: got %0d expected 6", got);
    end
    for (int i = 0; i < got; i++) begin
      vectors++;
      if (q_data[i] != 'h1000 + 100 + i || q_ch[i] != i % 2 ||
          q_sop[i] != int'(i % 2 == 0) ||
          q_eop[i] != int'(i % 2 == 1)) begin
        miscompares++;
        $display("FAIL oneshot_word%0d: got %h ch%0d s%0d e%0d expected %h ch%0d",
          i, q_data[i], q_ch[i], q_sop[i], q_eop[i],
          'h1000 + 100 + i, i % 2);
      end
    end
    pulses = dn;
    for (int c = 0; c < 8; c++) begin
      if (bus.done) pulses++;
      tick();
    end
    vectors++;
    if (pulses != 1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL oneshot_done: got pulses=%0d busy=%b expected 1/0",
        pulses, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    int got, bad, dn, pulses;
    bus.src_ready = 1'b0;
    start_play(100, 6, 1'b0);
    collect(6, 1'b1, 300, got, bad, dn);
    vectors++;
    if (got != 6 || bad != 0) begin
      miscompares++;
      $display("FAIL bp_count: got %0d words %0d unstable expected 6/0",
        got, bad);
    end
    for (int i = 0; i < got; i++) begin
      vectors++;
      if (q_data[i] != 'h1000 + 100 + i || q_ch[i] != i % 2) begin
        miscompares++;
        $display("FAIL bp_word%0d: got %h ch%0d expected %h ch%0d",
          i, q_data[i], q_ch[i], 'h1000 + 100 + i, i % 2);
      end
    end
    pulses = dn;
    for (int c = 0; c < 8; c++) begin
      if (bus.done) pulses++;
      tick();
    end
    vectors++;
    if (pulses != 1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_done: got pulses=%0d busy=%b expected 1/0",
        pulses, bus.busy);
    end
  endtask

  task automatic test_loop_wrap();
    int got, bad, dn, pulses;
    int exp_seq[4];
    exp_seq = '{'hBEE0, 'hBEE1, 'hBEE2, 'hBEE3};
    bus.src_ready = 1'b1;
    start_play(MAXA - 1, 4, 1'b1);
    tick();
    tick();
    vectors++;
    if (bus.src_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL loop_first: got valid=%b expected 1", bus.src_valid);
    end
    collect(12, 1'b0, 12, got, bad, dn);
    vectors++;
    if (got != 12) begin
      miscompares++;
      $display("FAIL loop_no_bubble: got %0d words in 12 cycles expected 12",
        got);
    end
    for (int i = 0; i < got; i++) begin
      vectors++;
      if (q_data[i] != exp_seq[i % 4] || q_ch[i] != i % 2) begin
        miscompares++;
        $display("FAIL loop_word%0d: got %h ch%0d expected %h ch%0d",
          i, q_data[i], q_ch[i], exp_seq[i % 4], i % 2);
      end
    end
    bus.ctl_stop = 1'b1;
    tick();
    bus.ctl_stop = 1'b0;
    bus.ctl_loop = 1'b0;
    vectors++;
    if (bus.src_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_valid: got valid=%b busy=%b expected 0/0",
        bus.src_valid, bus.busy);
    end
    pulses = dn;
    for (int c = 0; c < 5; c++) begin
      if (bus.done || bus.src_valid) pulses++;
      tick();
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL stop_no_done: got %0d done/valid cycles expected 0",
        pulses);
    end
  endtask

  task automatic test_odd_length();
    int got, bad, dn;
    bus.src_ready = 1'b1;
    start_play(100, 5, 1'b0);
    collect(5, 1'b0, 20, got, bad, dn);
    vectors++;
    if (got != 4 || dn != 1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL odd_len: got %0d words done=%0d busy=%b expected 4/1/0",
        got, dn, bus.busy);
    end
    vectors++;
    if (got > 3 && q_data[3] != 'h1000 + 103) begin
      miscompares++;
      $display("FAIL odd_len_last: got %h expected %h",
        q_data[3], 'h1000 + 103);
    end
  endtask

  task automatic test_zero_length();
    bus.src_ready = 1'b1;
    start_play(100, 0, 1'b0);
    vectors++;
    if ({bus.done, bus.busy, bus.src_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL zero_len: got done/busy/valid=%b expected 100",
        {bus.done, bus.busy, bus.src_valid});
    end
    tick();
    vectors++;
    if ({bus.done, bus.src_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL zero_len_pulse: got done/valid=%b expected 00",
        {bus.done, bus.src_valid});
    end
  endtask

  task automatic test_start_stop();
    bus.src_ready  = 1'b1;
    bus.ctl_stop   = 1'b1;
    start_play(100, 6, 1'b0);
    bus.ctl_stop   = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_stop_busy: got %b expected 0", bus.busy);
    end
    tick();
    tick();
    vectors++;
    if ({bus.src_valid, bus.done, bus.busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL start_stop_idle: got valid/done/busy=%b expected 000",
        {bus.src_valid, bus.done, bus.busy});
    end
  endtask

`ifdef AUDIO_MEM_POS_OUT_EN
  task automatic test_pos_out();
    int got, bad, dn;
    bus.src_ready = 1'b1;
    start_play(100, 4, 1'b1);
    collect(10, 1'b0, 30, got, bad, dn);
    vectors++;
    if (got != 10 || int'(bus.play_pos) != 2 ||
        int'(bus.loop_count) != 2) begin
      miscompares++;
      $display("FAIL pos_out: got n=%0d pos=%0d loops=%0d expected 10/2/2",
        got, bus.play_pos, bus.loop_count);
    end
    bus.src_ready = 1'b0;
    bus.ctl_stop  = 1'b1;
    tick();
    bus.ctl_stop  = 1'b0;
    bus.ctl_loop  = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_port_a();
    preload();
    test_one_shot();
    test_backpressure();
    test_loop_wrap();
    test_odd_length();
    test_zero_length();
    test_start_stop();
`ifdef AUDIO_MEM_POS_OUT_EN
    test_pos_out();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end

endmodule
